mem_responder: RTL

//  Synthesizable memory-side responder for the cache<->memory bus used by the data cache.

---
 rtl/mem_responder.sv | 68 ++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: synthesizable memory-side responder for the cache<->memory bus.
// Commands: 0 = BUS_NONE, 1 = BUS_LOAD, 2 = BUS_STORE, 3 = illegal (treated as none).
module mem_responder #(
    parameter int MEM_WORDS       = 1024,
    parameter int LATENCY         = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int XLEN            = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] cache2mem_addr,
    input  logic [63:0]     cache2mem_data,
    input  logic [1:0]      cache2mem_command,
    output logic [3:0]      mem2cache_response,
    output logic [63:0]     mem2cache_data,
    output logic [3:0]      mem2cache_tag
);
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam int AW = $clog2(MEM_WORDS);

    logic [63:0]   mem [MEM_WORDS];
    logic [3:0]    pipe_tag [LATENCY];
    logic [63:0]   pipe_data [LATENCY];
    logic [3:0]    next_tag;
    logic [AW-1:0] idx;
    logic [4:0]    busy;
    logic          is_load, is_store, accept;
    logic          unused_addr;

    assign idx         = cache2mem_addr[3+AW-1:3];
    assign unused_addr = ^{cache2mem_addr[XLEN-1:3+AW], cache2mem_addr[2:0]};
    assign is_load     = cache2mem_command == BUS_LOAD;
    assign is_store    = cache2mem_command == BUS_STORE;

    // The last stage is the load retiring this cycle, so its slot is already free.
    always_comb begin
        busy = '0;
        for (int i = 0; i < LATENCY - 1; i++) busy += 5'(pipe_tag[i] != 4'd0);
    end

    assign accept             = !rst && (is_store || (is_load && busy < 5'(MAX_OUTSTANDING)));
    assign mem2cache_response = accept ? next_tag : 4'd0;
    assign mem2cache_tag      = pipe_tag[LATENCY-1];
    assign mem2cache_data     = pipe_data[LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            next_tag <= 4'd1;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_tag[i]  <= '0;
                pipe_data[i] <= '0;
            end
        end else begin
            if (accept) next_tag <= (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
            pipe_tag[0]  <= (accept && is_load) ? next_tag : 4'd0;
            pipe_data[0] <= (accept && is_load) ? mem[idx] : 64'd0;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_tag[i]  <= pipe_tag[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && is_store) mem[idx] <= cache2mem_data;
    end
endmodule
